inst_mem_fetch_port: RTL

//  Parametrised instruction memory with a valid/ready fetch port, configurable read latency and fault reporting.

---
 rtl/inst_mem_pkg.sv | 20 ++
 rtl/fetch_rsp_fifo.sv | 64 ++++++
 rtl/inst_mem_fetch_port.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the instruction fetch port: fault flags,
// the canonical RV32I NOP and PC-to-word-index conversion.
package inst_mem_pkg;

  localparam logic [31:0] NOP_RV32I = 32'h0000_0013;

  // Widest PC any instance may use; PCs are zero-extended to this width
  // so the helper below can be shared across ADDR_W settings.
  localparam int PC_MAX_W = 64;

  typedef struct packed {
    logic oor;
    logic misaligned;
  } fetch_fault_t;

  function automatic logic [PC_MAX_W-1:0] word_idx(input logic [PC_MAX_W-1:0] pc);
    return pc >> 2;
  endfunction

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Small synchronous FIFO holding fetch responses; head is read combinationally
// so the consumer sees the oldest entry in the same cycle it becomes available.
module fetch_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so push-at-full with pop is legal.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      unique case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store_reg[wr_ptr_reg] <= push_data;
  end

  assign head_data = store_reg[rd_ptr_reg];

endmodule

// File: rtl/inst_mem_fetch_port.sv
// Instruction memory behind a valid/ready fetch port: fixed-latency read
// pipeline, credit-limited acceptance, in-order response buffer and fault tagging.
module inst_mem_fetch_port
  import inst_mem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 256,
  parameter int                LATENCY   = 1,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_RV32I)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_pc,
  input  logic                     flush,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_instr,
  output logic [ADDR_W-1:0]        rsp_pc,
  output logic [1:0]               rsp_fault,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int SLOTS   = LATENCY + 1;
  localparam int CRED_W  = $clog2(SLOTS + 1);
  localparam int ENTRY_W = ADDR_W + 2 + DATA_W;
  localparam int LAST    = LATENCY - 1;

  logic                run_reg;
  logic [CRED_W-1:0]   credits_reg;
  logic                req_fire;
  logic                rsp_fire;

  logic [PC_MAX_W-1:0] req_widx;
  logic                req_oor;
  logic                req_misaligned;
  fetch_fault_t        req_fault;
  logic [IDX_W-1:0]    rd_idx;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                stg_valid_reg [LATENCY];
  logic [ADDR_W-1:0]   stg_pc_reg    [LATENCY];
  fetch_fault_t        stg_fault_reg [LATENCY];
  logic [DATA_W-1:0]   stg_data_reg  [LATENCY];

  logic                last_valid;
  logic [DATA_W-1:0]   last_instr;
  logic [ENTRY_W-1:0]  last_entry;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [ENTRY_W-1:0]  rsp_entry;

  // ---------------- request side ----------------
  assign req_widx       = word_idx(PC_MAX_W'(req_pc));
  assign req_oor        = (req_widx >= PC_MAX_W'(DEPTH));
  assign req_misaligned = (req_pc[1:0] != 2'b00);
  assign req_fault      = '{oor: req_oor, misaligned: req_misaligned};
  assign rd_idx         = req_widx[IDX_W-1:0];

  // Credits cover every accepted request until its response is popped, so the
  // output buffer can never overflow however long the consumer stalls.
  assign req_ready = run_reg && !flush && (credits_reg < CRED_W'(SLOTS));
  assign req_fire  = req_valid && req_ready;

  // ---------------- memory array ----------------
  // Read-before-write: a fetch accepted alongside a prog write to the same
  // word returns the word as it was before this edge.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
    if (req_fire && !req_oor) stg_data_reg[0] <= mem[rd_idx];
  end

  // ---------------- latency pipeline ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_reg     <= 1'b0;
      credits_reg <= '0;
      for (int k = 0; k < LATENCY; k++) stg_valid_reg[k] <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (flush) begin
        credits_reg <= '0;
        for (int k = 0; k < LATENCY; k++) stg_valid_reg[k] <= 1'b0;
      end else begin
        credits_reg      <= credits_reg + CRED_W'(req_fire) - CRED_W'(rsp_fire);
        stg_valid_reg[0] <= req_fire;
        for (int k = 1; k < LATENCY; k++) stg_valid_reg[k] <= stg_valid_reg[k-1];
      end
    end
  end

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (req_fire) begin
          stg_pc_reg[0]    <= req_pc;
          stg_fault_reg[0] <= req_fault;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        stg_pc_reg[gi]    <= stg_pc_reg[gi-1];
        stg_fault_reg[gi] <= stg_fault_reg[gi-1];
        stg_data_reg[gi]  <= stg_data_reg[gi-1];
      end
    end
  end

  assign last_valid = stg_valid_reg[LAST];
  assign last_instr = (|stg_fault_reg[LAST]) ? NOP_INSTR : stg_data_reg[LAST];
  assign last_entry = {stg_pc_reg[LAST], stg_fault_reg[LAST], last_instr};

  // ---------------- response buffer ----------------
  // The last stage bypasses an empty buffer; it is only parked when older
  // entries are waiting or the consumer is not taking it this cycle.
  assign fifo_pop  = rsp_ready && !fifo_empty;
  assign fifo_push = last_valid && !(fifo_empty && rsp_ready);

  fetch_rsp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (SLOTS)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (last_entry),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty)
  );

  assign rsp_valid = !fifo_empty || last_valid;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign rsp_entry = fifo_empty ? last_entry : fifo_head;

  assign rsp_pc    = rsp_valid ? rsp_entry[ENTRY_W-1 -: ADDR_W] : '0;
  assign rsp_fault = rsp_valid ? rsp_entry[DATA_W +: 2]         : 2'b00;
  assign rsp_instr = rsp_valid ? rsp_entry[DATA_W-1:0]          : '0;

endmodule
